// File: rtl/branch_checkpoint_stack.sv
// Branch checkpoint stack: holds free-list snapshots for in-flight branches and
// drives a one-cycle free-list restore pulse on a mispredict.
module branch_checkpoint_stack #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned N               = 2,
    parameter int unsigned PR_SZ           = 64,
    parameter int unsigned TAG_W           = $clog2(DEPTH),
    parameter int unsigned PHYS_REG_IDX    = $clog2(PR_SZ),
    parameter int unsigned NUM_SCALAR_BITS = $clog2(N + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      branch_valid,
    input  logic [PR_SZ-1:0]          fl_snapshot,
    output logic [TAG_W-1:0]          branch_tag,
    output logic [DEPTH-1:0]          branch_mask,
    output logic                      stack_full,
    input  logic [N*PHYS_REG_IDX-1:0] phys_reg_retiring,
    input  logic [NUM_SCALAR_BITS-1:0] num_retiring_valid,
    input  logic                      resolve_valid,
    input  logic [TAG_W-1:0]          resolve_tag,
    input  logic                      resolve_mispredict,
    output logic                      restore_flag,
    output logic [PR_SZ-1:0]          free_list_restore,
    output logic [DEPTH-1:0]          squash_mask
);

    logic [DEPTH-1:0]             valid;
    logic [DEPTH-1:0][PR_SZ-1:0]  snap;
    logic [DEPTH-1:0][DEPTH-1:0]  dep;

    logic [PR_SZ-1:0] ret_list;
    logic [TAG_W-1:0] free_tag;
    logic [DEPTH-1:0] kill;
    logic [DEPTH-1:0] correct_clr;
    logic             mispredict;
    logic             correct;
    logic             alloc;

    always_comb begin
        ret_list = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (i < 32'(num_retiring_valid))
                ret_list[phys_reg_retiring[i*PHYS_REG_IDX +: PHYS_REG_IDX]] = 1'b1;
        end
    end

    // Scan from the top down so the lowest free index wins.
    always_comb begin
        free_tag = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (!valid[DEPTH-1-k])
                free_tag = TAG_W'(DEPTH-1-k);
        end
    end

    assign mispredict  = resolve_valid &  resolve_mispredict & valid[resolve_tag];
    assign correct     = resolve_valid & ~resolve_mispredict & valid[resolve_tag];
    assign correct_clr = correct ? (DEPTH'(1) << resolve_tag) : '0;
    assign stack_full  = &valid;
    assign branch_mask = valid;
    assign branch_tag  = free_tag;
    assign alloc       = branch_valid & ~stack_full & ~mispredict;

    always_comb begin
        kill = '0;
        for (int unsigned e = 0; e < DEPTH; e++)
            kill[e] = valid[e] & ((TAG_W'(e) == resolve_tag) | dep[e][resolve_tag]);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid             <= '0;
            snap              <= '0;
            dep               <= '0;
            restore_flag      <= 1'b0;
            free_list_restore <= '0;
            squash_mask       <= '0;
        end else begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
                if (valid[e])
                    snap[e] <= snap[e] | ret_list;
                dep[e] <= dep[e] & ~correct_clr;
                if (alloc && TAG_W'(e) == free_tag) begin
                    snap[e] <= fl_snapshot | ret_list;
                    dep[e]  <= valid & ~correct_clr;
                end
            end

            if (mispredict)
                valid <= valid & ~kill;
            else if (alloc)
                valid <= (valid & ~correct_clr) | (DEPTH'(1) << free_tag);
            else
                valid <= valid & ~correct_clr;

            restore_flag      <= mispredict;
            free_list_restore <= mispredict ? (snap[resolve_tag] | ret_list) : '0;
            squash_mask       <= mispredict ? kill : '0;
        end
    end

endmodule

// File: doc/branch_checkpoint_stack.md
# branch_checkpoint_stack

Holds free-list checkpoints for in-flight branches and drives the free list's `free_list_restore` / `restore_flag` inputs on a mispredict.
- Dispatch deposits a free-list snapshot per branch; execute later resolves that branch.
- On a correct prediction, the block releases the entry.
- On a mispredict, it restores the entry's snapshot one cycle later and squashes the entry plus every younger branch.
- Stored snapshots track retirements, so registers freed after a checkpoint stay free after restore.

## Interface
Parameters:
- `DEPTH`, 4: number of checkpoint entries; tag width `TAG_W = $clog2(DEPTH)`.
- `N`, `` `N ``: superscalar width (retire ports).
- `PR_SZ`, `` `PHYS_REG_SZ_R10K ``: physical register count / free-list width.

Ports:
- `clock` in 1: single clock, posedge.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `branch_valid` in 1: a branch dispatches this cycle (at most one per cycle).
- `fl_snapshot` in PR_SZ: free list after this cycle's dispatch allocations, captured with the branch.
- `branch_tag` out TAG_W: entry the dispatching branch receives (lowest free index); combinational.
- `branch_mask` out DEPTH: valid entries; dispatch tags instructions with it.
- `stack_full` out 1: all DEPTH entries valid.
- `phys_reg_retiring` in N×PHYS_REG_IDX: T_old registers retiring.
- `num_retiring_valid` in `` `NUM_SCALAR_BITS ``: count of valid `phys_reg_retiring` slots, from index 0.
- `resolve_valid` in 1: a branch resolves.
- `resolve_tag` in TAG_W: tag of the resolving branch.
- `resolve_mispredict` in 1: the resolving branch mispredicted.
- `restore_flag` out 1: registered; restore the free list this cycle.
- `free_list_restore` out PR_SZ: registered snapshot to restore.
- `squash_mask` out DEPTH: registered; entries killed by the mispredict (the resolving entry plus its dependents).

## Operation
Per-entry state:
- `valid`.
- `snap[PR_SZ]`.
- `dep[DEPTH]`: older entries this branch depends on.

Retire update:
- Build `ret_list`, a PR_SZ bitvector, with bits set for `phys_reg_retiring[i]` where i < `num_retiring_valid`.
- Every cycle, each valid entry does `snap |= ret_list`.

Allocate (when `branch_valid` & ~`stack_full` & no mispredict this cycle):
- Target entry is `branch_tag`.
- Set `valid`=1.
- `snap = fl_snapshot | ret_list`.
- `dep` = current `branch_mask` minus any entry resolving correctly this cycle.

Correct resolve (`resolve_valid` & ~`resolve_mispredict` & `valid[resolve_tag]`):
- Clear `valid[resolve_tag]`.
- Clear bit `resolve_tag` in every entry's `dep`.

Mispredict (`resolve_valid` & `resolve_mispredict` & `valid[resolve_tag]`):
- Kill set K = {`resolve_tag`} ∪ {e : `dep[e][resolve_tag]`}; clear `valid` for all of K.
- Next cycle: `restore_flag`=1, `free_list_restore = snap[resolve_tag] | ret_list` (the same-cycle `ret_list`), `squash_mask`=K.
- The dispatch allocation in that cycle is dropped.

Error cases and output values:
- Resolve of an invalid tag: ignored; no state change and no restore.
- Dispatch while `stack_full`: ignored; upstream must stall.
- `branch_tag` = lowest index with `valid`=0; 0 when full.
- `branch_mask` and `stack_full` reflect registered `valid` only. A slot freed this cycle is not reusable until next cycle.

## Timing
- Reset (`reset`=0, async):
  - All `valid`=0, `dep`=0, `snap`=0.
  - `restore_flag`=0, `free_list_restore`=0, `squash_mask`=0.
  - `branch_tag`=0, `branch_mask`=0, `stack_full`=0.
  - Reset asserted mid-restore clears a pending `restore_flag` immediately.
- Allocation is visible in `branch_mask` / `stack_full` the cycle after `branch_valid`.
- Mispredict to `restore_flag` latency is 1 cycle. `restore_flag` is a 1-cycle pulse; `free_list_restore` and `squash_mask` are valid only while it is high, and 0 otherwise.
- The free list applies `free_list_restore` at the edge after `restore_flag`. Retirements during the `restore_flag` cycle are handled by the free list, not by this block.
- Back-to-back mispredicts on consecutive cycles are legal; each produces its own pulse. The second is honored only if its tag is still valid after the first squash.
- Simultaneous events:
  - Dispatch + correct resolve: both are applied.
  - Dispatch + mispredict: only the mispredict is applied.
  - Retire + allocate: the retiring bits are ORed into the new `snap`.

## Test plan
- Reset, then dispatch 4 branches with `fl_snapshot`=0xF0, 0xE0, 0xC0, 0x80 → tags 0, 1, 2, 3; `stack_full`=1 on the cycle after the 4th. A 5th `branch_valid` changes nothing.
- Dispatch tags 0 and 1; resolve tag 0 correct; dispatch again → new branch gets tag 0; `dep[0]` = {1}, with no bit 0.
- Tags 0, 1, 2 valid; mispredict tag 1 → next cycle `restore_flag`=1, `free_list_restore`=snap[1], `squash_mask`=0b0110, `branch_mask`=0b0001.
- Checkpoint tag 0 with snapshot 0x0F; retire phys regs 5 and 9 (`num_retiring_valid`=2) two cycles later; mispredict tag 0 → `free_list_restore`=0x022F.
- Mispredict tag 0 in the same cycle as `branch_valid` with `fl_snapshot`=0xAA → no allocation; `branch_mask`=0 afterward; `restore_flag` pulses once.
- Mispredict pending, then `reset` pulled low before the next edge → `restore_flag` drops to 0 asynchronously; all outputs read 0.
